// File: rtl/hex_scan_display.sv
// Multiplexed hex 7-segment scanner with per-frame shadow latch and inter-digit blanking.
// Optional HEX_SCAN_LEADING_ZERO_BLANK_EN suppresses leading-zero digits during SHOW.
module hex_scan_display #(
  parameter int BITS         = 16,
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              enable_i,
  input  logic [BITS-1:0]   value_i,
  input  logic              value_valid_i,
  output logic [6:0]        seg_out,
  output logic [6:0]        seg_oeb,
  output logic [DIGITS-1:0] dig_out,
  output logic [DIGITS-1:0] dig_oeb,
  output logic              frame_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int NW = DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [PW-1:0]     r_pre;
  logic [PW-1:0]     w_pre_n;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_n;
  logic [BITS-1:0]   r_pend;
  logic [BITS-1:0]   r_shadow;
  logic [BITS-1:0]   w_shadow_n;
  logic              w_load;
  logic [NW-1:0]     w_pad;
  logic [3:0]        w_nib;
  logic              w_hide;
  logic [6:0]        w_glyph;
  logic [6:0]        w_seg_n;
  logic [6:0]        w_seg_oeb_n;
  logic [DIGITS-1:0] w_dig_n;
  logic [DIGITS-1:0] w_dig_oeb_n;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    w_state_n = r_state;
    w_pre_n   = r_pre;
    w_idx_n   = r_idx;
    w_load    = 1'b0;
    if (!enable_i) begin
      w_state_n = IDLE;
      w_pre_n   = '0;
      w_idx_n   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n = BLANK;
          w_pre_n   = '0;
          w_idx_n   = '0;
          w_load    = 1'b1;
        end
        BLANK: begin
          w_pre_n = r_pre + PW'(1);
          if (r_pre == PW'(BLANK_CYCLES - 1)) begin
            w_state_n = SHOW;
          end
        end
        SHOW: begin
          if (r_pre == PW'(PRESCALE - 1)) begin
            w_pre_n   = '0;
            w_state_n = BLANK;
            if (r_idx == IW'(DIGITS - 1)) begin
              w_idx_n = '0;
              w_load  = 1'b1;
            end else begin
              w_idx_n = r_idx + IW'(1);
            end
          end else begin
            w_pre_n = r_pre + PW'(1);
          end
        end
        default: begin
          w_state_n = IDLE;
          w_pre_n   = '0;
          w_idx_n   = '0;
        end
      endcase
    end
  end

  // A strobe on the load cycle bypasses pending so it is not lost for a frame
  always_comb begin
    w_shadow_n = r_shadow;
    if (w_load) begin
      w_shadow_n = value_valid_i ? value_i : r_pend;
    end
  end

  always_comb begin
    w_pad            = '0;
    w_pad[BITS-1:0]  = w_shadow_n;
    w_nib            = w_pad[{w_idx_n, 2'b00} +: 4];
    w_glyph          = glyph(w_nib);
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_hide = 1'b0;
    for (int d = 1; d < DIGITS; d++) begin
      if (IW'(d) == w_idx_n) begin
        w_hide = ~|(w_pad >> (4 * d));
      end
    end
  end
`else
  assign w_hide = 1'b0;
`endif

  always_comb begin
    w_seg_n     = '0;
    w_seg_oeb_n = '1;
    w_dig_n     = '0;
    w_dig_oeb_n = '1;
    unique case (w_state_n)
      BLANK: begin
        w_seg_oeb_n = '0;
        w_dig_oeb_n = '0;
        w_seg_n     = w_glyph;
      end
      SHOW: begin
        w_seg_oeb_n = '0;
        w_dig_oeb_n = '0;
        if (!w_hide) begin
          w_seg_n = w_glyph;
          w_dig_n = DIGITS'(1) << w_idx_n;
        end
      end
      default: begin
        w_seg_n = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_idx    <= '0;
      r_pend   <= '0;
      r_shadow <= '0;
      seg_out  <= '0;
      seg_oeb  <= '1;
      dig_out  <= '0;
      dig_oeb  <= '1;
      frame_o  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pre    <= w_pre_n;
      r_idx    <= w_idx_n;
      r_shadow <= w_shadow_n;
      if (value_valid_i) begin
        r_pend <= value_i;
      end
      seg_out  <= w_seg_n;
      seg_oeb  <= w_seg_oeb_n;
      dig_out  <= w_dig_n;
      dig_oeb  <= w_dig_oeb_n;
      frame_o  <= w_load;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: table vectors, directed corner sequences,
// and random stimulus against a frame-timeline reference model.
module tb_hex_scan_display;

  localparam int BITS   = 16;
  localparam int DIGITS = 4;
  localparam int PRE    = 8;
  localparam int BLK    = 2;
  localparam int FRAME  = DIGITS * PRE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] val;
  logic        valid;
  logic [6:0]  seg_out;
  logic [6:0]  seg_oeb;
  logic [3:0]  dig_out;
  logic [3:0]  dig_oeb;
  logic        frame_o;

  always #5 clk = ~clk;

  hex_scan_display #(
    .BITS(BITS),
    .DIGITS(DIGITS),
    .PRESCALE(PRE),
    .BLANK_CYCLES(BLK)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .enable_i(en),
    .value_i(val),
    .value_valid_i(valid),
    .seg_out(seg_out),
    .seg_oeb(seg_oeb),
    .dig_out(dig_out),
    .dig_oeb(dig_oeb),
    .frame_o(frame_o)
  );

  int checks = 0;
  int failures = 0;

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position within the frame timeline
  bit          m_act;
  int          m_t;
  logic [15:0] m_sh;
  logic [15:0] m_pd;
  bit          m_fr;

  logic [6:0]  cap_seg [4];
  logic [3:0]  cap_lit;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_sh = '0; m_pd = '0; m_fr = 0;
    end else begin
      m_fr = 0;
      if (!en) begin
        m_act = 0; m_t = 0;
      end else if (!m_act) begin
        m_act = 1; m_t = 0;
        m_sh = valid ? val : m_pd;
        m_fr = 1;
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t = 0;
          m_sh = valid ? val : m_pd;
          m_fr = 1;
        end
      end
      if (valid) m_pd = val;
    end
  endtask

  function automatic logic [22:0] model_out();
    logic [6:0]  s;
    logic [6:0]  so;
    logic [3:0]  d;
    logic [3:0]  dob;
    logic [15:0] sh;
    int          slot;
    int          off;
    s = '0; so = 7'h7F; d = '0; dob = 4'hF;
    if (m_act) begin
      slot = m_t / PRE;
      off  = m_t % PRE;
      sh   = m_sh >> (4 * slot);
      so   = '0;
      dob  = '0;
      s    = GLY[sh[3:0]];
      if (off >= BLK) d = 4'(1 << slot);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      if (slot > 0 && sh == 16'h0 && off >= BLK) begin
        s = '0;
        d = '0;
      end
`endif
    end
    return {s, so, d, dob, m_fr};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model", {9'h0, seg_out, seg_oeb, dig_out, dig_oeb, frame_o},
        {9'h0, model_out()});
  endtask

  task automatic capture();
    for (int d = 0; d < 4; d++) begin
      if (dig_out == 4'(1 << d)) begin
        cap_seg[d] = seg_out;
        cap_lit[d] = 1'b1;
      end
    end
  endtask

  // Records the current cycle plus the rest of one frame
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) cap_seg[d] = '0;
    cap_lit = '0;
    capture();
    for (int c = 1; c < FRAME; c++) begin
      step();
      capture();
    end
  endtask

  task automatic chk_frame(input string name, input logic [3:0][6:0] segs,
                           input logic [3:0] lit);
    for (int d = 0; d < 4; d++) chk(name, cap_seg[d], segs[d]);
    chk(name, cap_lit, lit);
  endtask

  typedef struct {
    logic [15:0]     v;
    logic [3:0][6:0] segs;
    logic [3:0]      lit;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int cnt;
    tbl[0] = '{16'h1A3F, {7'h06, 7'h77, 7'h4F, 7'h71}, 4'hF};
    tbl[1] = '{16'hBEEF, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'hF};
    tbl[2] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF};
    tbl[3] = '{16'h89CD, {7'h7F, 7'h6F, 7'h39, 7'h5E}, 4'hF};
    tbl[4] = '{16'h6E07, {7'h7D, 7'h79, 7'h3F, 7'h07}, 4'hF};
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    tbl[5] = '{16'h0005, {7'h00, 7'h00, 7'h00, 7'h6D}, 4'h1};
    tbl[6] = '{16'h0040, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'h3};
    tbl[7] = '{16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h1};
`else
    tbl[5] = '{16'h0005, {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'hF};
    tbl[6] = '{16'h0040, {7'h3F, 7'h3F, 7'h66, 7'h3F}, 4'hF};
    tbl[7] = '{16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF};
`endif

    rst_n = 1'b0; en = 1'b1; val = '0; valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_seg", seg_out, 7'h00);
      chk("rst_dig", dig_out, 4'h0);
      chk("rst_oeb", {seg_oeb, dig_oeb}, 11'h7FF);
      chk("rst_frame", frame_o, 1'b0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_frame", frame_o, 1'b1);
    chk("rel_blank", {dig_out, seg_oeb, dig_oeb}, 15'h0);
    chk("rel_seg", seg_out, 7'h3F);

    for (int i = 0; i < 8; i++) begin
      en = 1'b0;
      step();
      val = tbl[i].v; valid = 1'b1;
      step();
      valid = 1'b0; en = 1'b1;
      step();
      chk("tbl_frame", frame_o, 1'b1);
      capture_frame();
      chk_frame("tbl_digits", tbl[i].segs, tbl[i].lit);
    end

    en = 1'b0;
    step();
    val = 16'h1A3F; valid = 1'b1;
    step();
    valid = 1'b0; en = 1'b1;
    step();
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!frame_o && cnt < 100);
    chk("frame_period", cnt, FRAME);

    for (int i = 0; i < 2 * PRE + BLK; i++) step();
    val = 16'h0005; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("tear_d2", {dig_out, seg_out}, {4'b0100, 7'h77});
    for (int i = 0; i < 7; i++) step();
    chk("tear_d3", {dig_out, seg_out}, {4'b1000, 7'h06});
    for (int i = 0; i < 6; i++) step();
    chk("tear_load", frame_o, 1'b1);
    capture_frame();
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    chk_frame("tear_next", {7'h00, 7'h00, 7'h00, 7'h6D}, 4'h1);
`else
    chk_frame("tear_next", {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'hF);
`endif

    val = 16'hBEEF; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("bypass_frame", frame_o, 1'b1);
    capture_frame();
    chk_frame("bypass", {7'h7C, 7'h79, 7'h79, 7'h71}, 4'hF);

    for (int i = 0; i < 4; i++) step();
    chk("pre_drop", dig_out, 4'b0001);
    en = 1'b0;
    step();
    chk("drop_dig", dig_out, 4'h0);
    chk("drop_oeb", {seg_oeb, dig_oeb}, 11'h7FF);
    en = 1'b1;
    step();
    chk("reen_frame", frame_o, 1'b1);
    chk("reen_blank", dig_out, 4'h0);
    step();
    step();
    chk("reen_show", {dig_out, seg_out}, {4'b0001, 7'h71});

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 99) != 0);
      valid = ($urandom_range(0, 19) == 0);
      val   = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
